frame_bank_scheduler: RTL and testbench
=======================================

Name: frame_bank_scheduler

Overview:
- Ping-pong controller for the shared 2x192-word x 64-bit image BRAM.
- The SPI image writer always fills the back bank. The HUB75 BRAM reader always scans the front bank.
- Banks swap only at the reader's end-of-frame, and only after a complete back frame has been written. This removes tearing.
- Sits between the SPI image receiver, the simple-dual-port BRAM and the bus75 reader, in the 20 MHz domain.

Parameters:
- ADDR_W, 8, per-bank word address width.
- FRAME_WORDS, 192, words per complete frame; valid addresses are 0..FRAME_WORDS-1.
- DATA_W, 64, BRAM word width.
- OVR_W, 16, width of the dropped-word counter.

Ports:
- clk  in  1  20 MHz system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe from SPI image receiver.
- wr_addr  in  ADDR_W  per-bank word address of the write.
- wr_data  in  DATA_W  write word.
- wr_abort  in  1  level; while high, the partial back frame is discarded (driven from SPI_alt / new transfer).
- rd_en  in  1  read enable from the reader.
- rd_addr  in  ADDR_W  per-bank read address from the reader.
- rd_frame_done  in  1  one-cycle pulse from the reader after the last row of a scan.
- bram_cea  out  1  BRAM port-A enable.
- bram_ada  out  ADDR_W+1  port-A address {back_bank, addr}.
- bram_din  out  DATA_W  port-A data.
- bram_ceb  out  1  port-B enable (equals rd_en).
- bram_adb  out  ADDR_W+1  port-B address {front_bank, rd_addr}.
- front_bank  out  1  bank currently displayed.
- swap_pending  out  1  a complete back frame is waiting for a swap.
- frame_cnt  out  8  number of swaps performed, wraps at 255->0.
- ovr_cnt  out  OVR_W  words dropped, saturating.
- addr_err  out  1  sticky; set by any out-of-range write.

Behaviour:
- Reset values:
  - front_bank=0, so back bank=1.
  - swap_pending=0, frame_cnt=0, ovr_cnt=0, addr_err=0.
  - Internal word counter=0, state=FILL.
  - bram_cea=0, bram_ada=0, bram_din=0.
- Read path is combinational: bram_adb={front_bank, rd_addr}, bram_ceb=rd_en. Zero added latency.
- Write path is registered, one cycle:
  - bram_cea/ada/din reflect the previous cycle's accepted write.
  - A write is accepted when wr_en=1, state=FILL, wr_abort=0 and wr_addr<FRAME_WORDS.
  - An accepted write drives bram_ada={~front_bank, wr_addr}.
- Word counter: counts accepted writes, width ADDR_W+1. Duplicate addresses are counted, not filtered.
- State FILL:
  - When an accepted write brings the counter to FRAME_WORDS: go to READY next cycle, set swap_pending=1, clear the counter.
  - wr_abort=1: counter cleared, state stays FILL, the write in that cycle is dropped without counting as an overrun.
- State READY:
  - All wr_en writes are dropped (bram_cea=0) and ovr_cnt increments by 1 per dropped word, saturating at all-ones.
  - wr_abort has no effect; the completed frame is kept.
  - On rd_frame_done=1: front_bank toggles, swap_pending=0, frame_cnt+1, return to FILL.
- rd_frame_done while in FILL: ignored, no swap.
- Completion and rd_frame_done in the same cycle: the completion wins. Enter READY; the swap waits for the next rd_frame_done.
- Swap timing: the new front_bank is visible on bram_adb in the cycle after the rd_frame_done pulse.
- A registered write issued in the swap cycle still targets the old back bank, because its address was captured before the toggle.
- Out-of-range write (wr_addr>=FRAME_WORDS, wr_en=1):
  - Not written, not counted.
  - addr_err=1, cleared only by rst.
  - ovr_cnt is unchanged.
- rst mid-frame: everything returns to reset values in the next cycle; the partial frame is lost. Bank contents are not cleared.

Decomposition:
- Shared package holds:
  - State enum FILL/READY.
  - FRAME_WORDS_DEFAULT=192.
  - Bank-bit position constant, shared with the bus75 reader and the BRAM IP address width (9).
- One sub-module is natural: sat_counter (width parameter, inc, rst), used for ovr_cnt.
- Everything else stays in a single module.

Test Plan:
- Reset, then write words 0..191 with wr_en every other cycle -> swap_pending=1 exactly one cycle after the 192nd write. Then one rd_frame_done pulse -> front_bank=1, frame_cnt=1, swap_pending=0.
- Same as above, but rd_frame_done pulses before word 191 -> no swap, front_bank stays 0. Swap happens only on the first pulse after completion.
- In READY, issue 5 more writes -> bram_cea stays 0, ovr_cnt=5. Preload ovr_cnt near max -> it saturates at 0xFFFF.
- Write 100 words, pulse wr_abort, then write 192 words -> completion only after the full 192-word second frame.
- Write to addr 200 -> no bram_cea, addr_err=1 sticky through a later swap. rst clears it.
- rd_en=1 with rd_addr=0x15 -> bram_adb=0x015 before any swap and 0x115 after the first swap, same cycle as the input changes.
- Completion and rd_frame_done in the same cycle -> READY with no swap; the next rd_frame_done performs the swap.

Source files
------------

// File: rtl/frame_bank_scheduler_pkg.sv
// Shared definitions for the ping-pong image bank controller.
// The bank-select bit position is also used by the bus75 reader and the BRAM IP.
package frame_bank_scheduler_pkg;

   // Back-bank fill state: filling, or holding a complete frame for the next swap
   typedef enum logic {
      StFill,
      StReady
   } fbs_state_e;

   localparam int unsigned FRAME_WORDS_DEFAULT = 192;

   // Bank select is the MSB of the 9-bit BRAM address
   localparam int unsigned BANK_BIT    = 8;
   localparam int unsigned BRAM_ADDR_W = BANK_BIT + 1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;

   // Count increments, holding at the maximum value
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Ping-pong controller for the double-banked image BRAM: the SPI writer fills
// the back bank, the HUB75 reader scans the front bank, and the banks swap only
// at the reader's end of frame once a full back frame has been written.
module frame_bank_scheduler
   import frame_bank_scheduler_pkg::*;
#(
   parameter int unsigned ADDR_W      = BANK_BIT,
   parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned OVR_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_abort,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_frame_done,
   output logic              bram_cea,
   output logic [ADDR_W:0]   bram_ada,
   output logic [DATA_W-1:0] bram_din,
   output logic              bram_ceb,
   output logic [ADDR_W:0]   bram_adb,
   output logic              front_bank,
   output logic              swap_pending,
   output logic [7:0]        frame_cnt,
   output logic [OVR_W-1:0]  ovr_cnt,
   output logic              addr_err
);

   localparam logic [ADDR_W:0] FrameWordsW = FRAME_WORDS[ADDR_W:0];

   fbs_state_e        state_q;
   logic [ADDR_W:0]   cnt_q;
   logic              swap_pending_q;
   logic              front_q;
   logic [7:0]        frame_cnt_q;
   logic              addr_err_q;
   logic              cea_q;
   logic [ADDR_W:0]   ada_q;
   logic [DATA_W-1:0] din_q;

   logic              in_range;
   logic              wr_accept;
   logic              ovr_inc;
   logic [ADDR_W:0]   cnt_inc;

   // Classify this cycle's write: accepted into the back bank, or dropped as overrun
   always_comb begin
      in_range  = ({1'b0, wr_addr} < FrameWordsW);
      wr_accept = wr_en && in_range && !wr_abort && (state_q == StFill);
      ovr_inc   = wr_en && in_range && (state_q == StReady);
      cnt_inc   = cnt_q + (ADDR_W + 1)'(1);
   end

   // Fill/ready sequencing, frame completion and bank swap
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StFill;
         cnt_q          <= '0;
         swap_pending_q <= 1'b0;
         front_q        <= 1'b0;
         frame_cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StFill: begin
               // rd_frame_done is ignored here, so completion beats a coincident pulse
               if (wr_abort) begin
                  cnt_q <= '0;
               end else if (wr_accept) begin
                  if (cnt_inc == FrameWordsW) begin
                     state_q        <= StReady;
                     swap_pending_q <= 1'b1;
                     cnt_q          <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            StReady: begin
               if (rd_frame_done) begin
                  front_q        <= ~front_q;
                  swap_pending_q <= 1'b0;
                  frame_cnt_q    <= frame_cnt_q + 8'd1;
                  state_q        <= StFill;
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

   // Registered BRAM port A; the bank bit is captured with the write, before any toggle
   always_ff @(posedge clk) begin
      if (rst) begin
         cea_q <= 1'b0;
         ada_q <= '0;
         din_q <= '0;
      end else begin
         cea_q <= wr_accept;
         if (wr_accept) begin
            ada_q <= {~front_q, wr_addr};
            din_q <= wr_data;
         end
      end
   end

   // Sticky out-of-range write flag
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_err_q <= 1'b0;
      end else if (wr_en && !in_range) begin
         addr_err_q <= 1'b1;
      end
   end

   sat_counter #(
      .WIDTH (OVR_W)
   ) u_ovr_cnt (
      .clk (clk),
      .rst (rst),
      .inc (ovr_inc),
      .cnt (ovr_cnt)
   );

   assign bram_cea     = cea_q;
   assign bram_ada     = ada_q;
   assign bram_din     = din_q;
   assign bram_ceb     = rd_en;
   assign bram_adb     = {front_q, rd_addr};
   assign front_bank   = front_q;
   assign swap_pending = swap_pending_q;
   assign frame_cnt    = frame_cnt_q;
   assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Randomized and directed bench for frame_bank_scheduler against a frame-level model.
module tb_frame_bank_scheduler;

   localparam int FW      = 192;
   localparam int OVR_W   = 4;
   localparam int OVR_MAX = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        wr_abort = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_addr = '0;
   logic        rd_frame_done = 1'b0;
   logic        bram_cea;
   logic [8:0]  bram_ada;
   logic [63:0] bram_din;
   logic        bram_ceb;
   logic [8:0]  bram_adb;
   logic        front_bank;
   logic        swap_pending;
   logic [7:0]  frame_cnt;
   logic [OVR_W-1:0] ovr_cnt;
   logic        addr_err;

   frame_bank_scheduler #(
      .ADDR_W      (8),
      .FRAME_WORDS (FW),
      .DATA_W      (64),
      .OVR_W       (OVR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_abort      (wr_abort),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_frame_done (rd_frame_done),
      .bram_cea      (bram_cea),
      .bram_ada      (bram_ada),
      .bram_din      (bram_din),
      .bram_ceb      (bram_ceb),
      .bram_adb      (bram_adb),
      .front_bank    (front_bank),
      .swap_pending  (swap_pending),
      .frame_cnt     (frame_cnt),
      .ovr_cnt       (ovr_cnt),
      .addr_err      (addr_err)
   );

   always #25 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Emulated BRAM built from the DUT's port A, and the bench's own idea of its contents
   logic [63:0] shadow [0:511];
   logic [63:0] mdl_mem [0:1][0:FW-1];

   always @(posedge clk) begin
      if (bram_cea) shadow[bram_ada] <= bram_din;
   end

   // Frame-level model state
   bit          m_front;
   bit          m_ready;
   int          m_words;
   int          m_frames;
   int          m_ovr;
   bit          m_err;
   bit          m_cea;
   logic [8:0]  m_ada;
   logic [63:0] m_din;

   task automatic model_reset();
      m_front = 0; m_ready = 0; m_words = 0; m_frames = 0;
      m_ovr = 0; m_err = 0; m_cea = 0; m_ada = '0; m_din = '0;
   endtask

   task automatic check_bank(input bit bank);
      int bad = 0;
      for (int a = 0; a < FW; a++) begin
         if (shadow[{bank, a[7:0]}] !== mdl_mem[bank][a]) bad++;
      end
      check_eq("frame_data", 64'(bad), 64'd0);
   endtask

   // One clock: drive inputs, check read port combinationally, step model, check outputs
   task automatic cycle(input bit r, input bit we, input logic [7:0] wa, input logic [63:0] wd,
                        input bit ab, input bit re, input logic [7:0] ra, input bit fd);
      bit swapped = 0;
      bit in_rng;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
      wr_abort = ab; rd_en = re; rd_addr = ra; rd_frame_done = fd;
      #1;
      check_eq("ceb", 64'(bram_ceb), 64'(re));
      check_eq("adb", 64'(bram_adb), 64'({m_front, ra}));
      @(posedge clk);
      in_rng = (int'(wa) < FW);
      if (r) begin
         model_reset();
      end else begin
         m_cea = 0;
         if (we && !in_rng) m_err = 1;
         if (m_ready) begin
            if (we && in_rng && m_ovr < OVR_MAX) m_ovr++;
            if (fd) begin
               m_front = !m_front; m_ready = 0; m_frames = (m_frames + 1) % 256;
               swapped = 1;
            end
         end else if (ab) begin
            m_words = 0;
         end else if (we && in_rng) begin
            m_cea = 1; m_ada = {!m_front, wa}; m_din = wd;
            mdl_mem[!m_front][wa] = wd;
            m_words++;
            if (m_words == FW) begin m_ready = 1; m_words = 0; end
         end
      end
      #1;
      check_eq("cea", 64'(bram_cea), 64'(m_cea));
      check_eq("ada", 64'(bram_ada), 64'(m_ada));
      check_eq("din", bram_din, m_din);
      check_eq("front", 64'(front_bank), 64'(m_front));
      check_eq("pending", 64'(swap_pending), 64'(m_ready));
      check_eq("frame_cnt", 64'(frame_cnt), 64'(m_frames));
      check_eq("ovr_cnt", 64'(ovr_cnt), 64'(m_ovr));
      check_eq("addr_err", 64'(addr_err), 64'(m_err));
      if (swapped) check_bank(m_front);
   endtask

   task automatic wr(input logic [7:0] a);
      cycle(0, 1, a, {$urandom, $urandom}, 0, 0, 8'h0, 0);
   endtask

   task automatic idle(input bit fd);
      cycle(0, 0, 8'h0, 64'h0, 0, 0, 8'h0, fd);
   endtask

   task automatic do_reset();
      cycle(1, 0, 8'h0, 64'h0, 0, 0, 8'h0, 0);
   endtask

   task automatic fill_frame();
      for (int i = 0; i < FW; i++) wr(i[7:0]);
   endtask

   initial begin
      for (int i = 0; i < 512; i++) shadow[i] = '0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < FW; a++) mdl_mem[b][a] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check_eq("rst_pending", 64'(swap_pending), 64'd0);
      check_eq("rst_front", 64'(front_bank), 64'd0);

      // Read address before any swap
      cycle(0, 0, 8'h0, 64'h0, 0, 1, 8'h15, 0);
      rd_en = 1; rd_addr = 8'h15; #1;
      check_eq("adb_pre_swap", 64'(bram_adb), 64'h015);

      // Full frame written every other cycle, then one swap
      for (int i = 0; i < FW; i++) begin
         check_eq("pend_before", 64'(swap_pending), 64'd0);
         wr(i[7:0]);
         idle(0);
      end
      check_eq("pend_after_frame", 64'(swap_pending), 64'd1);
      idle(1);
      check_eq("front_t1", 64'(front_bank), 64'd1);
      check_eq("frames_t1", 64'(frame_cnt), 64'd1);
      check_eq("pend_t1", 64'(swap_pending), 64'd0);
      rd_en = 1; rd_addr = 8'h15; #1;
      check_eq("adb_post_swap", 64'(bram_adb), 64'h115);
      cycle(0, 0, 8'h0, 64'h0, 0, 1, 8'h15, 0);

      // Early frame-done is ignored; swap on first pulse after completion
      for (int i = 0; i < FW; i++) begin
         if (i == 100) cycle(0, 1, i[7:0], {$urandom, $urandom}, 0, 0, 8'h0, 1);
         else wr(i[7:0]);
      end
      check_eq("front_noswap", 64'(front_bank), 64'd1);
      idle(0);
      idle(1);
      check_eq("front_t2", 64'(front_bank), 64'd0);

      // Overrun counting and saturation
      do_reset();
      fill_frame();
      for (int i = 0; i < 5; i++) wr(8'(i + 3));
      check_eq("ovr_5", 64'(ovr_cnt), 64'd5);
      for (int i = 0; i < 20; i++) wr(8'(i));
      check_eq("ovr_sat", 64'(ovr_cnt), 64'(OVR_MAX));
      cycle(0, 1, 8'h7, 64'h0, 1, 0, 8'h0, 0);
      check_eq("ready_abort_kept", 64'(swap_pending), 64'd1);
      idle(1);

      // Abort mid-frame restarts the count
      for (int i = 0; i < 100; i++) wr(i[7:0]);
      cycle(0, 1, 8'h5, 64'h0, 1, 0, 8'h0, 0);
      for (int i = 0; i < FW - 1; i++) wr(i[7:0]);
      check_eq("abort_not_done", 64'(swap_pending), 64'd0);
      wr(8'd191);
      check_eq("abort_done", 64'(swap_pending), 64'd1);
      idle(1);

      // Out-of-range write, sticky through a swap, cleared by reset
      wr(8'd200);
      check_eq("oor_err", 64'(addr_err), 64'd1);
      fill_frame();
      idle(1);
      check_eq("oor_sticky", 64'(addr_err), 64'd1);
      do_reset();
      check_eq("oor_cleared", 64'(addr_err), 64'd0);

      // Completion coincident with frame-done: no swap until next pulse
      for (int i = 0; i < FW - 1; i++) wr(i[7:0]);
      cycle(0, 1, 8'd191, {$urandom, $urandom}, 0, 0, 8'h0, 1);
      check_eq("coinc_pending", 64'(swap_pending), 64'd1);
      check_eq("coinc_front", 64'(front_bank), 64'd0);
      idle(1);
      check_eq("coinc_swap", 64'(front_bank), 64'd1);

      // Reset mid-frame
      for (int i = 0; i < 50; i++) wr(i[7:0]);
      do_reset();

      // Random traffic
      for (int n = 0; n < 6000; n++) begin
         bit          we = ($urandom % 4) != 0;
         logic [7:0]  wa = (($urandom % 32) == 0) ? 8'(192 + $urandom % 64) : 8'($urandom % FW);
         bit          ab = ($urandom % 400) == 0;
         bit          fd = ($urandom % 60) == 0;
         bit          r  = ($urandom % 3000) == 0;
         cycle(r, we, wa, {$urandom, $urandom}, ab, 1'($urandom), 8'($urandom), fd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
